// File: rtl/csa_pkg.sv
// Shared types and width helpers for the carry-save accumulator engine.
package csa_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    function automatic int acc_w(input int bits, input int n_in, input int max_beats);
        return bits + $clog2(n_in) + $clog2(max_beats);
    endfunction

    function automatic int cpa_chunk(input int accW, input int stages);
        return (accW + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/csa_compress_tree.sv
// Combinational carry-save reducer: N+2 operands of width W down to a sum/carry pair.
module csa_compress_tree #(
    parameter int W = 14,
    parameter int N = 4
) (
    input  logic [(N+2)*W-1:0] ops_i,
    output logic [W-1:0]       sum_o,
    output logic [W-1:0]       carry_o
);

    // Each 3:2 layer folds one more operand into the running redundant pair.
    always_comb begin
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W-1:0] x;
        logic [W-1:0] t;
        s = ops_i[0 +: W];
        c = ops_i[W +: W];
        x = '0;
        t = '0;
        for (int k = 2; k < N + 2; k++) begin
            x = ops_i[k*W +: W];
            t = s ^ c ^ x;
            c = ((s & c) | (s & x) | (c & x)) << 1;
            s = t;
        end
        sum_o   = s;
        carry_o = c;
    end

endmodule

// File: rtl/csa_accum_engine.sv
// Multi-beat carry-save accumulator with a chunked, pipelined carry-propagate resolve
// and a valid/ready result port.
module csa_accum_engine
    import csa_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int N_IN       = 4,
    parameter int MAX_BEATS  = 16,
    parameter int CPA_STAGES = 2,
    parameter bit SIGNED     = 1'b0,
    localparam int ACC_W     = acc_w(BITS, N_IN, MAX_BEATS),
    localparam int BEAT_W    = $clog2(MAX_BEATS) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*BITS-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     result,
    output logic [BEAT_W-1:0]    beats,
    output logic                 overflow,
    output logic                 busy
);

    localparam int CHUNK = cpa_chunk(ACC_W, CPA_STAGES);
    localparam int PAD_W = CHUNK * CPA_STAGES;
    localparam int STG_W = (CPA_STAGES > 1) ? $clog2(CPA_STAGES) : 1;
    localparam logic [STG_W-1:0]  LAST_STG = STG_W'(CPA_STAGES - 1);
    localparam logic [BEAT_W-1:0] MAX_CNT  = BEAT_W'(MAX_BEATS);

    state_t                    state_q;
    logic [ACC_W-1:0]          vs_q, vc_q, vs_d, vc_d;
    logic [(N_IN+2)*ACC_W-1:0] treeOps;
    logic [PAD_W-1:0]          cpa_q, cpa_d;
    logic                      carry_q;
    logic [STG_W-1:0]          stg_q;
    logic [CHUNK:0]            chunkSum;
    logic [ACC_W-1:0]          res_q;
    logic [BEAT_W-1:0]         beats_q;
    logic                      ovf_q;
    logic                      outValid_q;

    always_comb begin
        logic [BITS-1:0] opRaw;
        opRaw   = '0;
        treeOps = '0;
        treeOps[0 +: ACC_W]     = vs_q;
        treeOps[ACC_W +: ACC_W] = vc_q;
        for (int i = 0; i < N_IN; i++) begin
            opRaw = in_data[i*BITS +: BITS];
            treeOps[(i+2)*ACC_W +: ACC_W] = SIGNED ? {{(ACC_W-BITS){opRaw[BITS-1]}}, opRaw}
                                                   : {{(ACC_W-BITS){1'b0}}, opRaw};
        end
    end

    csa_compress_tree #(.W(ACC_W), .N(N_IN)) u_tree (
        .ops_i   (treeOps),
        .sum_o   (vs_d),
        .carry_o (vc_d)
    );

    // Chunk stg_q of vs+vc; the carry chain restarts at the LSB chunk.
    always_comb begin
        logic [PAD_W-1:0] vsPad, vcPad;
        logic [CHUNK-1:0] opA, opB;
        logic             cin;
        vsPad    = PAD_W'(vs_q);
        vcPad    = PAD_W'(vc_q);
        opA      = CHUNK'(vsPad >> (int'(stg_q) * CHUNK));
        opB      = CHUNK'(vcPad >> (int'(stg_q) * CHUNK));
        cin      = (stg_q == '0) ? 1'b0 : carry_q;
        chunkSum = {1'b0, opA} + {1'b0, opB} + {{CHUNK{1'b0}}, cin};
        cpa_d    = ((stg_q == '0) ? '0 : cpa_q) |
                   (PAD_W'(chunkSum[CHUNK-1:0]) << (int'(stg_q) * CHUNK));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            vs_q       <= '0;
            vc_q       <= '0;
            cpa_q      <= '0;
            carry_q    <= 1'b0;
            stg_q      <= '0;
            res_q      <= '0;
            beats_q    <= '0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else if (abort) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vs_q    <= '0;
                        vc_q    <= '0;
                        beats_q <= '0;
                        ovf_q   <= 1'b0;
                        stg_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        vs_q <= vs_d;
                        vc_q <= vc_d;
                        if (beats_q != '1)
                            beats_q <= beats_q + 1'b1;
                        if (beats_q == MAX_CNT)
                            ovf_q <= 1'b1;
                        if (in_last) begin
                            stg_q   <= '0;
                            state_q <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    cpa_q   <= cpa_d;
                    carry_q <= chunkSum[CHUNK];
                    if (stg_q == LAST_STG) begin
                        stg_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        stg_q <= stg_q + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle loads the output register; afterwards wait for the handshake.
                    if (!outValid_q) begin
                        res_q      <= cpa_q[ACC_W-1:0];
                        outValid_q <= 1'b1;
                    end else if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign result    = res_q;
    assign beats     = beats_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_csa_accum_engine.sv
// Directed bench for csa_accum_engine: default, signed, and a 5-operand / 3-stage-CPA instance.
module tb_csa_accum_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready, out_valid, overflow, busy;
    logic [13:0] result;
    logic [4:0]  beats;

    logic        sInReady, sOutValid, sOverflow, sBusy;
    logic [13:0] sResult;
    logic [4:0]  sBeats;

    logic        start5 = 1'b0, inValid5 = 1'b0, inLast5 = 1'b0, outReady5 = 1'b0;
    logic [39:0] inData5 = '0;
    logic        inReady5, outValid5, overflow5, busy5;
    logic [14:0] result5;
    logic [4:0]  beats5;

    int passCount = 0;
    int checkCount = 0;

    csa_accum_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .beats(beats), .overflow(overflow), .busy(busy)
    );

    csa_accum_engine #(.SIGNED(1'b1)) dutS (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(sInReady), .in_data(in_data), .in_last(in_last),
        .out_valid(sOutValid), .out_ready(out_ready), .result(sResult),
        .beats(sBeats), .overflow(sOverflow), .busy(sBusy)
    );

    csa_accum_engine #(.N_IN(5), .CPA_STAGES(3)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .abort(1'b0),
        .in_valid(inValid5), .in_ready(inReady5), .in_data(inData5), .in_last(inLast5),
        .out_valid(outValid5), .out_ready(outReady5), .result(result5),
        .beats(beats5), .overflow(overflow5), .busy(busy5)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendBeat(input logic [31:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    // Counts edges from the last accepted beat until out_valid rises, bounded.
    task automatic waitValid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #11;
        checkCount++; if (result !== 14'd0) $display("[TB] FAIL reset_result: got %0d, expected 0", result); else passCount++;
        checkCount++; if (beats !== 5'd0) $display("[TB] FAIL reset_beats: got %0d, expected 0", beats); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b, expected 0", overflow); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); else passCount++;
        checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy); else passCount++;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        int n;
        doStart();
        checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL accum_in_ready: got %b, expected 1", in_ready); else passCount++;
        sendBeat(32'h04030201, 1'b1);
        waitValid(n);
        checkCount++; if (n !== 3) $display("[TB] FAIL single_latency: got %0d, expected 3", n); else passCount++;
        checkCount++; if (result !== 14'd10) $display("[TB] FAIL single_result: got %0d, expected 10", result); else passCount++;
        checkCount++; if (beats !== 5'd1) $display("[TB] FAIL single_beats: got %0d, expected 1", beats); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL single_overflow: got %b, expected 0", overflow); else passCount++;
        checkCount++; if (sResult !== 14'd10) $display("[TB] FAIL single_signed_result: got %0d, expected 10", sResult); else passCount++;
        handshake();
        checkCount++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL single_release: got valid=%b busy=%b, expected 0 0", out_valid, busy); else passCount++;
    endtask

    task automatic test_max_beats();
        int n;
        doStart();
        for (int i = 0; i < 16; i++) sendBeat(32'hFFFFFFFF, i == 15);
        waitValid(n);
        checkCount++; if (n !== 3) $display("[TB] FAIL max16_latency: got %0d, expected 3", n); else passCount++;
        checkCount++; if (result !== 14'd16320) $display("[TB] FAIL max16_result: got %0d, expected 16320", result); else passCount++;
        checkCount++; if (beats !== 5'd16) $display("[TB] FAIL max16_beats: got %0d, expected 16", beats); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL max16_overflow: got %b, expected 0", overflow); else passCount++;
        handshake();
        doStart();
        for (int i = 0; i < 17; i++) begin
            sendBeat(32'hFFFFFFFF, i == 16);
            if (i == 15) begin
                checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_at16: got %b, expected 0", overflow); else passCount++;
            end
        end
        waitValid(n);
        checkCount++; if (result !== 14'd956) $display("[TB] FAIL max17_result: got %0d, expected 956", result); else passCount++;
        checkCount++; if (beats !== 5'd17) $display("[TB] FAIL max17_beats: got %0d, expected 17", beats); else passCount++;
        checkCount++; if (overflow !== 1'b1) $display("[TB] FAIL max17_overflow: got %b, expected 1", overflow); else passCount++;
        handshake();
    endtask

    task automatic test_signed();
        int n;
        doStart();
        for (int i = 0; i < 3; i++) sendBeat(32'hFFFFFFFF, i == 2);
        waitValid(n);
        checkCount++; if (sResult !== 14'h3FF4) $display("[TB] FAIL signed_result: got %h, expected 3ff4", sResult); else passCount++;
        checkCount++; if (sBeats !== 5'd3) $display("[TB] FAIL signed_beats: got %0d, expected 3", sBeats); else passCount++;
        checkCount++; if (result !== 14'd3060) $display("[TB] FAIL unsigned_3x: got %0d, expected 3060", result); else passCount++;
        handshake();
    endtask

    task automatic test_backpressure();
        int n;
        doStart();
        sendBeat(32'h281E140A, 1'b1);
        waitValid(n);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checkCount++;
            if (out_valid !== 1'b1 || result !== 14'd100 || in_ready !== 1'b0 || busy !== 1'b1)
                $display("[TB] FAIL hold_cycle%0d: got valid=%b result=%0d ready=%b busy=%b, expected 1 100 0 1",
                         c, out_valid, result, in_ready, busy);
            else passCount++;
        end
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b0;
        checkCount++; if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("[TB] FAIL done_start_ignored: got busy=%b valid=%b, expected 0 0", busy, out_valid); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL idle_stays: got busy=%b, expected 0", busy); else passCount++;
    endtask

    task automatic test_abort();
        int n;
        logic seen;
        doStart();
        sendBeat(32'h01010101, 1'b0);
        sendBeat(32'h01010101, 1'b0);
        abort = 1'b1; in_valid = 1'b1; in_data = 32'h01010101;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0; in_data = '0;
        checkCount++; if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("[TB] FAIL abort_idle: got busy=%b ready=%b, expected 0 0", busy, in_ready); else passCount++;
        checkCount++; if (beats !== 5'd2) $display("[TB] FAIL abort_beat_dropped: got %0d, expected 2", beats); else passCount++;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checkCount++; if (seen !== 1'b0) $display("[TB] FAIL abort_no_valid: got %b, expected 0", seen); else passCount++;
        doStart();
        sendBeat(32'h00000005, 1'b1);
        waitValid(n);
        checkCount++; if (result !== 14'd5) $display("[TB] FAIL after_abort_result: got %0d, expected 5", result); else passCount++;
        checkCount++; if (beats !== 5'd1) $display("[TB] FAIL after_abort_beats: got %0d, expected 1", beats); else passCount++;
        handshake();
    endtask

    task automatic test_async_reset();
        doStart();
        sendBeat(32'h09090909, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkCount++;
        if (result !== 14'd0 || beats !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || overflow !== 1'b0)
            $display("[TB] FAIL async_reset: got result=%0d beats=%0d busy=%b ready=%b valid=%b ovf=%b, expected all 0",
                     result, beats, busy, in_ready, out_valid, overflow);
        else passCount++;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checkCount++; if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("[TB] FAIL post_reset_idle: got busy=%b ready=%b, expected 0 0", busy, in_ready); else passCount++;
    endtask

    task automatic run5(input logic [39:0] d0, input logic [39:0] d, input int nBeats,
                        input logic [14:0] expRes, input logic [4:0] expBeats, input logic expOvf);
        int n;
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            inValid5 = 1'b1; inData5 = (i == 0) ? d0 : d; inLast5 = (i == nBeats - 1);
            @(posedge clk); #1;
            inValid5 = 1'b0; inLast5 = 1'b0; inData5 = '0;
        end
        n = 0;
        while (outValid5 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkCount++; if (n !== 4) $display("[TB] FAIL n5_latency: got %0d, expected 4", n); else passCount++;
        checkCount++; if (result5 !== expRes) $display("[TB] FAIL n5_result: got %0d, expected %0d", result5, expRes); else passCount++;
        checkCount++; if (beats5 !== expBeats || overflow5 !== expOvf)
            $display("[TB] FAIL n5_beats_ovf: got %0d/%b, expected %0d/%b", beats5, overflow5, expBeats, expOvf); else passCount++;
        outReady5 = 1'b1;
        @(posedge clk); #1;
        outReady5 = 1'b0;
        checkCount++; if (outValid5 !== 1'b0 || busy5 !== 1'b0)
            $display("[TB] FAIL n5_release: got valid=%b busy=%b, expected 0 0", outValid5, busy5); else passCount++;
    endtask

    task automatic test_sweep();
        run5(40'h0504030201, 40'h6464646464, 2, 15'd515, 5'd2, 1'b0);
        run5(40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 3, 15'd3825, 5'd3, 1'b0);
        run5(40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 20, 15'd25500, 5'd20, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_max_beats();
        test_signed();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_sweep();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
